sha256_msg_schedule: RTL and testbench
======================================

// Module: sha256_msg_schedule
// PURPOSE
//   Producer side of the SHA-256 round datapath: accepts one 512-bit block as 16 x 32-bit words and
//   emits the expanded message schedule W[0..ROUNDS-1], one word per handshake, to the round engine
//   (which applies the Sigma/Ch/Maj functions). Sits between block padding and compression rounds.
// PARAMETERS
//   ROUNDS   64   words emitted per block; legal range 16..64; values outside this range are a fatal elaboration error
// PORTS
//   clk        in   1   rising-edge clock, single clock domain
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   input word valid
//   in_ready   out  1   input word accepted when in_valid & in_ready
//   in_data    in   32  message word M[i], big-endian word order, i = 0..15
//   out_valid  out  1   schedule word valid
//   out_ready  in   1   consumer (round engine) ready
//   out_data   out  32  W[t]
//   out_last   out  1   high with W[ROUNDS-1]
//   out_idx    out  6   t of current out_data (only with SCHED_IDX_EN)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, count=0, window cleared, in_ready=0, out_valid=0,
//     out_data=0, out_last=0. All outputs are registered or decoded from registered state only.
//   Reset may assert at any point, including mid-load or mid-emit; the partial block is discarded.
//   FSM: IDLE -> LOAD unconditionally on the next clk edge.
//        LOAD: in_ready=1; each accept writes in_data into window[count] and increments count.
//              On the 16th accept: count <= 0 and state -> EMIT. out_valid rises on the following cycle.
//        EMIT: out_valid=1, out_data=window[0]. On each out handshake:
//              - the window shifts down by one word;
//              - window[15] <= s1(window[14]) + window[9] + s0(window[1]) + window[0] (mod 2^32);
//              - count increments.
//              On the handshake with count==ROUNDS-1: state -> IDLE.
//        In IDLE, in_ready=0 and out_valid=0, giving a one-cycle bubble between blocks.
//   s0(x) = rotr7 ^ rotr18 ^ shr3; s1(x) = rotr17 ^ rotr19 ^ shr10. All sums wrap modulo 2^32.
//   Throughput: 1 word/cycle in each phase. Block latency: 16 load + 1 + ROUNDS emit cycles.
//   Backpressure: while out_ready=0, out_data, out_last and out_valid hold stable.
//     out_valid never drops without a handshake.
//   The input and output phases never overlap. in_valid during EMIT/IDLE is ignored (no accept).
//   out_last = (state==EMIT) && (count==ROUNDS-1).
//   count width is 7 bits; it never exceeds ROUNDS-1 and never wraps.
// CONFIGURATION
//   SCHED_IDX_EN defined:
//     out_idx port exists and equals count[5:0] while out_valid=1.
//     out_idx resets to 0.
//   SCHED_IDX_EN undefined:
//     out_idx port is absent.
//     Consumers track the round index themselves using out_last.
// STRUCTURE
//   sha256_pkg: SHA256_WORD_W=32, SHA256_BLOCK_WORDS=16, state encoding localparams
//     (IDLE/LOAD/EMIT), functions small_sigma0/small_sigma1.
//   Sub-module sha256_sched_next: purely combinational next-word adder
//     (inputs w0, w1, w9, w14; output w16), built on the existing rotr module.
//   Window: 16 x 32-bit shift register; no RAM.
// TESTING
//   1. "abc" block (W0=61626380, W1..W14=0, W15=00000018), out_ready=1
//      -> W16=61626380, W17=000F0000, W18=7DA86405, W19=600003C6, W20=3E9D7B78;
//      all 64 words match the golden model; out_last only at t=63.
//   2. Random out_ready (50%) on the "abc" block
//      -> identical word sequence; out_data stable while stalled; 64 handshakes total.
//   3. rst_n pulsed low after 8 loaded words
//      -> out_valid=0 and in_ready=0 during reset;
//      -> a fresh 16-word load then yields the correct schedule.
//   4. in_valid held high across a block boundary
//      -> no accept during EMIT or the IDLE bubble; the next block is loaded cleanly.
//   5. ROUNDS=16, all-ones input block
//      -> outputs W0..W15 = FFFFFFFF exactly; out_last on the 16th word; no expansion words emitted.
//   6. SCHED_IDX_EN defined
//      -> out_idx steps 0..63 in step with handshakes and resets to 0.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message-schedule block.
//   SHA256_WORD_W      : word width in bits
//   SHA256_BLOCK_WORDS : message words per 512-bit block
//   sched_state_e      : schedule FSM encoding (IDLE / LOAD / EMIT)
//   small_sigma0/1     : SHA-256 message-expansion functions s0/s1
package sha256_pkg;

  localparam int SHA256_WORD_W      = 32;
  localparam int SHA256_BLOCK_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } sched_state_e;

  function automatic logic [SHA256_WORD_W-1:0] small_sigma0(input logic [SHA256_WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [SHA256_WORD_W-1:0] small_sigma1(input logic [SHA256_WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/rotr.sv
// Fixed rotate-right of a 32-bit word by SHIFT positions (pure wiring).
//   x : input word
//   y : x rotated right by SHIFT
module rotr #(
  parameter int SHIFT = 1
) (
  input  logic [31:0] x,
  output logic [31:0] y
);

  assign y = {x[SHIFT-1:0], x[31:SHIFT]};

endmodule

// File: rtl/sha256_sched_next.sv
// Combinational next-word generator of the SHA-256 message schedule:
//   w16 = s1(w14) + w9 + s0(w1) + w0   (mod 2^32)
// Ports:
//   w0, w1, w9, w14 : window taps W[t-16], W[t-15], W[t-7], W[t-2]
//   w16             : W[t]
module sha256_sched_next
  import sha256_pkg::*;
(
  input  logic [SHA256_WORD_W-1:0] w0,
  input  logic [SHA256_WORD_W-1:0] w1,
  input  logic [SHA256_WORD_W-1:0] w9,
  input  logic [SHA256_WORD_W-1:0] w14,
  output logic [SHA256_WORD_W-1:0] w16
);

  logic [SHA256_WORD_W-1:0] r7, r18, r17, r19;
  logic [SHA256_WORD_W-1:0] s0, s1;

  rotr #(.SHIFT(7))  u_r7  (.x(w1),  .y(r7));
  rotr #(.SHIFT(18)) u_r18 (.x(w1),  .y(r18));
  rotr #(.SHIFT(17)) u_r17 (.x(w14), .y(r17));
  rotr #(.SHIFT(19)) u_r19 (.x(w14), .y(r19));

  assign s0  = r7 ^ r18 ^ (w1 >> 3);
  assign s1  = r17 ^ r19 ^ (w14 >> 10);
  assign w16 = s1 + w9 + s0 + w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule producer. Loads one block as 16 words, then
// emits W[0..ROUNDS-1] one word per output handshake, using a 16-word
// shift-register window that appends the expanded word on every emit.
//
// Handshakes: a transfer occurs on a rising clk edge where valid & ready
// are both high; a raised out_valid is held, with out_data/out_last stable,
// until that transfer happens. Load and emit phases never overlap, and a
// one-cycle IDLE bubble separates consecutive blocks.
//
// Parameters: ROUNDS (16..64) words emitted per block.
// Optional feature macro: SCHED_IDX_EN adds out_idx (round index t).
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : message word handshake, in_data = M[i]
//   out_valid/out_ready: schedule word handshake, out_data = W[t]
//   out_last           : high with W[ROUNDS-1]
//   out_idx            : t of out_data (SCHED_IDX_EN only)
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SHA256_WORD_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SHA256_WORD_W-1:0] out_data,
  output logic                     out_last
`ifdef SCHED_IDX_EN
  ,
  output logic [5:0]               out_idx
`endif
);

  if (ROUNDS < 16 || ROUNDS > 64) begin : g_rounds_check
    $fatal(1, "sha256_msg_schedule: ROUNDS must be within 16..64");
  end

  localparam logic [6:0] LAST_IDX  = 7'(ROUNDS - 1);
  localparam logic [6:0] LOAD_LAST = 7'(SHA256_BLOCK_WORDS - 1);

  sched_state_e             state, state_next;
  logic [6:0]               count;
  logic [SHA256_WORD_W-1:0] window [SHA256_BLOCK_WORDS];
  logic [SHA256_WORD_W-1:0] w_new;
  logic                     in_hs, out_hs;

  // Handshake-visible outputs are decoded from registered state only.
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == EMIT);
  assign out_data  = window[0];
  assign out_last  = (state == EMIT) && (count == LAST_IDX);
`ifdef SCHED_IDX_EN
  assign out_idx   = count[5:0];
`endif

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  sha256_sched_next u_next (
    .w0  (window[0]),
    .w1  (window[1]),
    .w9  (window[9]),
    .w14 (window[14]),
    .w16 (w_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = LOAD;
      LOAD: if (in_hs && count == LOAD_LAST) state_next = EMIT;
      EMIT: if (out_hs && count == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // count indexes the load slot in LOAD and the round t in EMIT; it returns
  // to zero at the end of each phase so it never exceeds ROUNDS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < SHA256_BLOCK_WORDS; i++) window[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_hs) begin
            window[count[3:0]] <= in_data;
            count <= (count == LOAD_LAST) ? 7'd0 : count + 7'd1;
          end
        end
        EMIT: begin
          if (out_hs) begin
            // Shift out W[t]; W[t+16] enters at the top. Expansion words
            // computed past W[ROUNDS-1] are simply never emitted.
            for (int i = 0; i < SHA256_BLOCK_WORDS - 1; i++) window[i] <= window[i+1];
            window[SHA256_BLOCK_WORDS-1] <= w_new;
            count <= (count == LAST_IDX) ? 7'd0 : count + 7'd1;
          end
        end
        default: count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: a 64-round instance and a
// 16-round instance share the stimulus signals, gated by sel16.
module tb_sha256_msg_schedule;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, out_ready, sel16;
  logic [31:0] in_data;

  logic        in_valid_a, in_valid_b, out_ready_a, out_ready_b;
  logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_last_a, out_last_b;
  logic [31:0] out_data_a, out_data_b;
  logic [5:0]  out_idx_a, out_idx_b;

  assign in_valid_a  = in_valid  & ~sel16;
  assign in_valid_b  = in_valid  &  sel16;
  assign out_ready_a = out_ready & ~sel16;
  assign out_ready_b = out_ready &  sel16;

  sha256_msg_schedule #(.ROUNDS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_last(out_last_a)
`ifdef SCHED_IDX_EN
    , .out_idx(out_idx_a)
`endif
  );

  sha256_msg_schedule #(.ROUNDS(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_last(out_last_b)
`ifdef SCHED_IDX_EN
    , .out_idx(out_idx_b)
`endif
  );

`ifndef SCHED_IDX_EN
  assign out_idx_a = '0;
  assign out_idx_b = '0;
`endif

  wire        o_in_ready = sel16 ? in_ready_b  : in_ready_a;
  wire        o_valid    = sel16 ? out_valid_b : out_valid_a;
  wire        o_last     = sel16 ? out_last_b  : out_last_a;
  wire [31:0] o_data     = sel16 ? out_data_b  : out_data_a;
  wire [5:0]  o_idx      = sel16 ? out_idx_b   : out_idx_a;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] blk [16];
  logic [31:0] abc_ref [5];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule straight from the SHA-256 recurrence.
  function automatic void model(input int rounds);
    logic [31:0] w [64];
    logic [31:0] a, b;
    for (int t = 0; t < rounds; t++) begin
      if (t < 16) begin
        w[t] = blk[t];
      end else begin
        a = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
        b = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = b + w[t-7] + a + w[t-16];
      end
      exp_q.push_back(w[t]);
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Presents n words at negedges; leaves in_valid high after the last one.
  task automatic load_block(input int n, input int rounds);
    int waits;
    for (int i = 0; i < n; i++) begin
      waits = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = blk[i];
      while (!o_in_ready && waits < 100) begin
        @(negedge clk);
        waits++;
      end
      if (waits >= 100) begin
        chk("load_timeout", {31'b0, o_in_ready}, 32'd1);
        return;
      end
    end
    if (n == 16) model(rounds);
  endtask

  // Collects n words; hold_valid keeps in_valid high with junk data.
  task automatic drain(input int n, input bit rand_ready, input bit hold_valid, input bit check_abc);
    int k = 0;
    int guard = 0;
    bit stalled = 0;
    logic [31:0] held = '0;
    logic held_last = 1'b0;
    logic [31:0] e;
    while (k < n && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (hold_valid) in_data = 32'hDEADBEEF;
      else in_valid = 1'b0;
      if (stalled) begin
        chk("stall_valid", {31'b0, o_valid}, 32'd1);
        chk("stall_data", o_data, held);
        chk("stall_last", {31'b0, o_last}, {31'b0, held_last});
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_valid) begin
        chk("in_ready_emit", {31'b0, o_in_ready}, 32'd0);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            e = '0;
          end else begin
            e = exp_q.pop_front();
          end
          chk("w_data", o_data, e);
          chk("w_last", {31'b0, o_last}, {31'b0, (k == n - 1)});
`ifdef SCHED_IDX_EN
          chk("out_idx", {26'b0, o_idx}, 32'(k[5:0]));
`endif
          if (check_abc && k >= 16 && k <= 20) chk("abc_ref", o_data, abc_ref[k-16]);
          k++;
          stalled = 0;
        end else begin
          held = o_data;
          held_last = o_last;
          stalled = 1;
        end
      end
    end
    if (k < n) chk("drain_timeout", 32'(k), 32'(n));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    // IDLE bubble: nothing offered or accepted for one cycle.
    @(negedge clk);
    chk("bubble_valid", {31'b0, o_valid}, 32'd0);
    chk("bubble_ready", {31'b0, o_in_ready}, 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic rand_block();
    for (int i = 0; i < 16; i++) blk[i] = $urandom();
  endtask

  task automatic abc_block();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    abc_ref[0] = 32'h61626380;
    abc_ref[1] = 32'h000F0000;
    abc_ref[2] = 32'h7DA86405;
    abc_ref[3] = 32'h600003C6;
    abc_ref[4] = 32'h3E9D7B78;
    sel16 = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid_a}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready_a}, 32'd0);
    chk("rst_out_data", out_data_a, 32'd0);
    chk("rst_out_last", {31'b0, out_last_a}, 32'd0);
    chk("rst16_out_valid", {31'b0, out_valid_b}, 32'd0);
    chk("rst16_in_ready", {31'b0, in_ready_b}, 32'd0);
`ifdef SCHED_IDX_EN
    chk("rst_out_idx", {26'b0, out_idx_a}, 32'd0);
`endif
    rst_n = 1'b1;

    // "abc" block at full rate, with published W16..W20.
    abc_block();
    load_block(16, 64);
    drain(64, 1'b0, 1'b0, 1'b1);

    // Same block under random backpressure.
    load_block(16, 64);
    drain(64, 1'b1, 1'b0, 1'b1);

    // Reset mid-load; partial block discarded.
    rand_block();
    load_block(8, 64);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid_a}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready_a}, 32'd0);
    chk("midrst_out_data", out_data_a, 32'd0);
`ifdef SCHED_IDX_EN
    chk("midrst_out_idx", {26'b0, out_idx_a}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    rand_block();
    load_block(16, 64);
    drain(64, 1'b1, 1'b0, 1'b0);

    // in_valid held high across the block boundary.
    rand_block();
    load_block(16, 64);
    drain(64, 1'b0, 1'b1, 1'b0);
    rand_block();
    load_block(16, 64);
    drain(64, 1'b1, 1'b0, 1'b0);

    // ROUNDS=16 instance with an all-ones block: no expansion words out.
    sel16 = 1'b1;
    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
    load_block(16, 16);
    drain(16, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "time limit");
  end

endmodule
